// File: rtl/cnn_mem_phase_arbiter.sv
// Phase sequencer and shared feature-RAM / weight-ROM port arbiter for the CNN layer engines.
// Optional macro CNN_MEMARB_PERF_EN builds a saturating busy-cycle counter on perf_cycles.
module cnn_mem_phase_arbiter #(
    parameter int N_CLIENTS = 3,
    parameter int N_PHASES  = 4,
    // Phase p selects its client from bits [p*CW +: CW]; this default yields clients 0,2,1,0.
    parameter logic [N_PHASES*((N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1)-1:0] PHASE_MAP = {2'd0, 2'd1, 2'd2, 2'd0},
    parameter int RAM_AW    = 16,
    parameter int DW        = 8,
    parameter int ROM_AW    = 15,
    parameter int GUARD     = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic [N_CLIENTS-1:0]          phase_start,
    input  logic [N_CLIENTS-1:0]          phase_done,
    input  logic [N_CLIENTS*RAM_AW-1:0]   cl_ram_w_addr,
    input  logic [N_CLIENTS*DW-1:0]       cl_ram_w_data,
    input  logic [N_CLIENTS-1:0]          cl_ram_w_en,
    input  logic [N_CLIENTS-1:0]          cl_ram_wea,
    input  logic [N_CLIENTS*RAM_AW-1:0]   cl_ram_r_addr,
    input  logic [N_CLIENTS-1:0]          cl_ram_r_en,
    input  logic [N_CLIENTS*ROM_AW-1:0]   cl_rom_addr,
    input  logic [N_CLIENTS-1:0]          cl_rom_en,
    input  logic [RAM_AW-1:0]             tb_ram_r_addr,
    input  logic                          tb_ram_r_en,
    output logic [RAM_AW-1:0]             ram_w_addr,
    output logic [DW-1:0]                 ram_w_data,
    output logic                          ram_w_en,
    output logic                          ram_wea,
    output logic [RAM_AW-1:0]             ram_r_addr,
    output logic                          ram_r_en,
    output logic [ROM_AW-1:0]             rom_addr,
    output logic                          rom_en,
    output logic [$clog2(N_PHASES+1)-1:0] cur_phase,
    output logic                          busy,
    output logic                          all_done,
    output logic [31:0]                   perf_cycles,
    output logic [1:0]                    dbg_state
);
    localparam int CW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int PW = $clog2(N_PHASES + 1);
    localparam logic [3:0]    GUARD_LAST = 4'(GUARD);
    localparam logic [PW-1:0] LAST_PHASE = PW'(N_PHASES - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_GUARD = 2'd2, S_TB = 2'd3} state_t;

    state_t               r_state, w_state_nxt;
    logic [PW-1:0]        r_phase, w_phase_nxt;
    logic [3:0]           r_gcnt;
    logic                 w_start_pulse, w_run_req, w_grant, w_done_sel;
    logic [CW-1:0]        w_cur_client, w_nxt_client;
    logic [N_CLIENTS-1:0] w_nxt_onehot, r_phase_start;
    logic [RAM_AW-1:0]    w_m_w_addr, w_m_r_addr, r_ram_w_addr, r_ram_r_addr;
    logic [DW-1:0]        w_m_w_data, r_ram_w_data;
    logic [ROM_AW-1:0]    w_m_rom_addr, r_rom_addr;
    logic                 w_m_w_en, w_m_wea, w_m_r_en, w_m_rom_en;
    logic                 r_ram_w_en, r_ram_wea, r_ram_r_en, r_rom_en;

    function automatic logic [CW-1:0] client_of(input logic [PW-1:0] p);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N_PHASES; i++)
            if (p == PW'(i)) c = PHASE_MAP[i*CW +: CW];
        return c;
    endfunction

    assign w_cur_client = client_of(r_phase);
    assign w_nxt_client = client_of(w_phase_nxt);
    assign w_run_req    = start && (r_state == S_IDLE || r_state == S_TB);

    always_comb begin
        w_done_sel = 1'b0;
        for (int c = 0; c < N_CLIENTS; c++)
            if (w_cur_client == CW'(c)) w_done_sel = phase_done[c];
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_start_pulse = 1'b0;
        case (r_state)
            S_IDLE, S_TB: begin
                if (w_run_req) begin
                    w_state_nxt   = S_RUN;
                    w_phase_nxt   = '0;
                    w_start_pulse = 1'b1;
                end
            end
            S_RUN: begin
                if (w_done_sel) w_state_nxt = S_GUARD;
            end
            S_GUARD: begin
                if (r_gcnt == GUARD_LAST) begin
                    if (r_phase == LAST_PHASE) begin
                        w_state_nxt = S_TB;
                        w_phase_nxt = PW'(N_PHASES);
                    end else begin
                        w_state_nxt   = S_RUN;
                        w_phase_nxt   = r_phase + 1'b1;
                        w_start_pulse = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The port carries the current client through its done cycle and the next client from the entry edge.
    assign w_grant = (r_state == S_RUN) || (w_state_nxt == S_RUN);

    always_comb begin
        w_nxt_onehot = '0;
        w_m_w_addr   = '0;
        w_m_w_data   = '0;
        w_m_w_en     = 1'b0;
        w_m_wea      = 1'b0;
        w_m_r_addr   = '0;
        w_m_r_en     = 1'b0;
        w_m_rom_addr = '0;
        w_m_rom_en   = 1'b0;
        for (int c = 0; c < N_CLIENTS; c++) begin
            if (w_nxt_client == CW'(c)) begin
                w_nxt_onehot[c] = 1'b1;
                w_m_w_addr      = cl_ram_w_addr[c*RAM_AW +: RAM_AW];
                w_m_w_data      = cl_ram_w_data[c*DW +: DW];
                w_m_w_en        = cl_ram_w_en[c];
                w_m_wea         = cl_ram_wea[c];
                w_m_r_addr      = cl_ram_r_addr[c*RAM_AW +: RAM_AW];
                w_m_r_en        = cl_ram_r_en[c];
                w_m_rom_addr    = cl_rom_addr[c*ROM_AW +: ROM_AW];
                w_m_rom_en      = cl_rom_en[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_phase       <= '0;
            r_gcnt        <= '0;
            r_phase_start <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_phase       <= w_phase_nxt;
            r_gcnt        <= (r_state == S_GUARD) ? r_gcnt + 1'b1 : 4'd0;
            r_phase_start <= w_start_pulse ? w_nxt_onehot : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_w_addr <= '0;
            r_ram_w_data <= '0;
            r_ram_w_en   <= 1'b0;
            r_ram_wea    <= 1'b0;
            r_ram_r_addr <= '0;
            r_ram_r_en   <= 1'b0;
            r_rom_addr   <= '0;
            r_rom_en     <= 1'b0;
        end else if (w_grant) begin
            r_ram_w_addr <= w_m_w_addr;
            r_ram_w_data <= w_m_w_data;
            r_ram_w_en   <= w_m_w_en;
            r_ram_wea    <= w_m_wea;
            r_ram_r_addr <= w_m_r_addr;
            r_ram_r_en   <= w_m_r_en;
            r_rom_addr   <= w_m_rom_addr;
            r_rom_en     <= w_m_rom_en;
        end else begin
            r_ram_w_en <= 1'b0;
            r_ram_wea  <= 1'b0;
            r_rom_en   <= 1'b0;
            if (r_state == S_TB) begin
                r_ram_r_addr <= tb_ram_r_addr;
                r_ram_r_en   <= tb_ram_r_en;
            end else begin
                r_ram_r_en <= 1'b0;
            end
        end
    end

    assign phase_start = r_phase_start;
    assign ram_w_addr  = r_ram_w_addr;
    assign ram_w_data  = r_ram_w_data;
    assign ram_w_en    = r_ram_w_en;
    assign ram_wea     = r_ram_wea;
    assign ram_r_addr  = r_ram_r_addr;
    assign ram_r_en    = r_ram_r_en;
    assign rom_addr    = r_rom_addr;
    assign rom_en      = r_rom_en;
    assign cur_phase   = r_phase;
    assign busy        = (r_state == S_RUN) || (r_state == S_GUARD);
    assign all_done    = (r_state == S_TB);
    assign dbg_state   = r_state;

`ifdef CNN_MEMARB_PERF_EN
    logic [31:0] r_perf;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            r_perf <= '0;
        else if (w_run_req)                    r_perf <= '0;
        else if (busy && r_perf != 32'hFFFF_FFFF) r_perf <= r_perf + 32'd1;
    end
    assign perf_cycles = r_perf;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_cnn_mem_phase_arbiter.sv
// Directed bench for cnn_mem_phase_arbiter: phase order, guard timing, port muxing, TB read-back, reset abort.
module tb_cnn_mem_phase_arbiter;
    localparam int NC = 3;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int RW = 15;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_GUARD = 2'd2, ST_TB = 2'd3;
`ifdef CNN_MEMARB_PERF_EN
    localparam logic [31:0] EXP_PERF = 32'd52;
`else
    localparam logic [31:0] EXP_PERF = 32'd0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [NC-1:0]     phase_start, phase_done;
    logic [NC*AW-1:0]  cl_ram_w_addr, cl_ram_r_addr;
    logic [NC*DW-1:0]  cl_ram_w_data;
    logic [NC-1:0]     cl_ram_w_en, cl_ram_wea, cl_ram_r_en, cl_rom_en;
    logic [NC*RW-1:0]  cl_rom_addr;
    logic [AW-1:0]     tb_ram_r_addr;
    logic              tb_ram_r_en;
    logic [AW-1:0]     ram_w_addr, ram_r_addr;
    logic [DW-1:0]     ram_w_data;
    logic              ram_w_en, ram_wea, ram_r_en, rom_en;
    logic [RW-1:0]     rom_addr;
    logic [2:0]        cur_phase;
    logic              busy, all_done;
    logic [31:0]       perf_cycles;
    logic [1:0]        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    cnn_mem_phase_arbiter dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .phase_start(phase_start), .phase_done(phase_done),
        .cl_ram_w_addr(cl_ram_w_addr), .cl_ram_w_data(cl_ram_w_data),
        .cl_ram_w_en(cl_ram_w_en), .cl_ram_wea(cl_ram_wea),
        .cl_ram_r_addr(cl_ram_r_addr), .cl_ram_r_en(cl_ram_r_en),
        .cl_rom_addr(cl_rom_addr), .cl_rom_en(cl_rom_en),
        .tb_ram_r_addr(tb_ram_r_addr), .tb_ram_r_en(tb_ram_r_en),
        .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data), .ram_w_en(ram_w_en), .ram_wea(ram_wea),
        .ram_r_addr(ram_r_addr), .ram_r_en(ram_r_en),
        .rom_addr(rom_addr), .rom_en(rom_en),
        .cur_phase(cur_phase), .busy(busy), .all_done(all_done),
        .perf_cycles(perf_cycles), .dbg_state(dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; phase_done = '0;
        cl_ram_w_addr = '0; cl_ram_w_data = '0; cl_ram_w_en = '0; cl_ram_wea = '0;
        cl_ram_r_addr = '0; cl_ram_r_en = '0; cl_rom_addr = '0; cl_rom_en = '0;
        tb_ram_r_addr = '0; tb_ram_r_en = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({ram_w_addr, ram_w_data, ram_w_en, ram_wea, ram_r_addr, ram_r_en, rom_addr, rom_en} !== '0) begin
            n_fail++; $display("FAIL reset_ports: got %h expected 0",
                {ram_w_addr, ram_w_data, ram_w_en, ram_wea, ram_r_addr, ram_r_en, rom_addr, rom_en});
        end
        n_checks++;
        if ({phase_start, cur_phase, busy, all_done} !== '0) begin
            n_fail++; $display("FAIL reset_ctrl: got %h expected 0", {phase_start, cur_phase, busy, all_done});
        end
        n_checks++;
        if (perf_cycles !== 32'd0) begin
            n_fail++; $display("FAIL reset_perf: got %0d expected 0", perf_cycles);
        end
        rst_n = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (dbg_state !== ST_IDLE || phase_start !== '0) begin
            n_fail++; $display("FAIL idle_after_reset: state %0d phase_start %b expected 0/000", dbg_state, phase_start);
        end
    endtask

    // Each client pulses done in the tenth cycle of its phase (phase_start cycle counted as the first),
    // so each run spans 13 busy cycles: 10 RUN plus 3 GUARD-state cycles.
    task automatic test_phase_order();
        int order[$];
        int ps_cyc[$];
        int done_cyc[$];
        int gaps[$];
        int cnt[NC];
        int exp_order[4];
        int zero_run;
        bit seen_en;
        bit got_all;
        int all_cyc;
        exp_order = '{0, 2, 1, 0};
        for (int c = 0; c < NC; c++) begin
            cnt[c] = 0;
            cl_ram_r_addr[c*AW +: AW] = 16'h0100 * 16'(c + 1);
        end
        cl_ram_r_en = '1;
        zero_run = 0; seen_en = 0; got_all = 0; all_cyc = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 300 && !got_all; k++) begin
            if (phase_start !== '0) begin
                n_checks++;
                if (!$onehot(phase_start)) begin
                    n_fail++; $display("FAIL start_onehot: got %b expected one-hot", phase_start);
                end
                for (int c = 0; c < NC; c++)
                    if (phase_start[c]) begin order.push_back(c); ps_cyc.push_back(cyc); cnt[c] = 10; end
            end
            if (ram_r_en) begin
                if (seen_en && zero_run > 0) gaps.push_back(zero_run);
                seen_en = 1; zero_run = 0;
            end else if (seen_en) begin
                zero_run++;
            end
            if (all_done) begin
                got_all = 1; all_cyc = cyc;
                n_checks++;
                if (perf_cycles !== EXP_PERF) begin
                    n_fail++; $display("FAIL perf_at_all_done: got %0d expected %0d", perf_cycles, EXP_PERF);
                end
            end
            phase_done = '0;
            for (int c = 0; c < NC; c++)
                if (cnt[c] != 0) begin
                    cnt[c]--;
                    if (cnt[c] == 0) begin phase_done[c] = 1'b1; done_cyc.push_back(cyc); end
                end
            if (!got_all) tick();
        end
        phase_done = '0;
        n_checks++;
        if (!got_all) begin
            n_fail++; $display("FAIL all_done_timeout: all_done not seen within 300 cycles");
        end
        n_checks++;
        if (order.size() != 4 || done_cyc.size() != 4) begin
            n_fail++; $display("FAIL phase_count: got %0d starts/%0d dones expected 4/4", order.size(), done_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (order[i] != exp_order[i]) begin
                    n_fail++; $display("FAIL phase_order[%0d]: got client %0d expected %0d", i, order[i], exp_order[i]);
                end
            end
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (ps_cyc[i+1] - done_cyc[i] != 4) begin
                    n_fail++; $display("FAIL done_to_start[%0d]: got %0d cycles expected 4", i, ps_cyc[i+1] - done_cyc[i]);
                end
            end
            n_checks++;
            if (got_all && all_cyc - done_cyc[3] != 4) begin
                n_fail++; $display("FAIL done_to_all_done: got %0d cycles expected 4", all_cyc - done_cyc[3]);
            end
        end
        n_checks++;
        if (gaps.size() != 3) begin
            n_fail++; $display("FAIL gap_count: got %0d expected 3", gaps.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (gaps[i] != 2) begin
                    n_fail++; $display("FAIL gap_len[%0d]: got %0d expected 2", i, gaps[i]);
                end
            end
        end
    endtask

    task automatic test_tb_read();
        tb_ram_r_addr = 16'h00FF; tb_ram_r_en = 1'b1;
        tick();
        n_checks++;
        if (ram_r_addr !== 16'h00FF || ram_r_en !== 1'b1) begin
            n_fail++; $display("FAIL tb_read: got %h/%b expected 00ff/1", ram_r_addr, ram_r_en);
        end
        n_checks++;
        if (ram_w_en !== 1'b0 || rom_en !== 1'b0 || all_done !== 1'b1) begin
            n_fail++; $display("FAIL tb_enables: got w_en %b rom_en %b all_done %b expected 0/0/1", ram_w_en, rom_en, all_done);
        end
        tb_ram_r_addr = 16'h0A0B;
        tick();
        n_checks++;
        if (ram_r_addr !== 16'h0A0B) begin
            n_fail++; $display("FAIL tb_read_follow: got %h expected 0a0b", ram_r_addr);
        end
        tb_ram_r_en = 1'b0;
        tick();
        n_checks++;
        if (ram_r_en !== 1'b0) begin
            n_fail++; $display("FAIL tb_read_off: got %b expected 0", ram_r_en);
        end
    endtask

    task automatic test_rerun_mux();
        cl_ram_r_en = '0;
        cl_ram_w_addr[0*AW +: AW] = 16'hBEEF; cl_ram_w_data[0*DW +: DW] = 8'h5A;
        cl_ram_w_en[0] = 1'b1; cl_ram_wea[0] = 1'b1;
        cl_rom_addr[0*RW +: RW] = 15'h7EEF; cl_rom_en[0] = 1'b1;
        cl_ram_w_addr[2*AW +: AW] = 16'h0000; cl_ram_w_data[2*DW +: DW] = 8'h00;
        cl_ram_w_en[2] = 1'b0; cl_ram_wea[2] = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (phase_start !== 3'b001 || cur_phase !== 3'd0 || dbg_state !== ST_RUN) begin
            n_fail++; $display("FAIL rerun_start: got %b/%0d/%0d expected 001/0/1", phase_start, cur_phase, dbg_state);
        end
        phase_done = 3'b001;
        tick();
        phase_done = '0;
        n_checks++;
        if (dbg_state !== ST_GUARD || ram_w_addr !== 16'hBEEF || ram_w_en !== 1'b1) begin
            n_fail++; $display("FAIL coincident_done: got state %0d addr %h en %b expected 2/beef/1", dbg_state, ram_w_addr, ram_w_en);
        end
        tick();
        n_checks++;
        if (ram_w_en !== 1'b0 || rom_en !== 1'b0 || ram_w_addr !== 16'hBEEF) begin
            n_fail++; $display("FAIL guard_hold: got en %b rom_en %b addr %h expected 0/0/beef", ram_w_en, rom_en, ram_w_addr);
        end
        tick();
        tick();
        n_checks++;
        if (phase_start !== 3'b100 || cur_phase !== 3'd1) begin
            n_fail++; $display("FAIL phase1_start: got %b/%0d expected 100/1", phase_start, cur_phase);
        end
        cl_ram_w_addr[2*AW +: AW] = 16'h1234; cl_ram_w_data[2*DW +: DW] = 8'hA5;
        cl_ram_w_en[2] = 1'b1; cl_ram_wea[2] = 1'b1;
        cl_rom_addr[2*RW +: RW] = 15'h0ABC; cl_rom_en[2] = 1'b1;
        tick();
        n_checks++;
        if ({ram_w_addr, ram_w_data, ram_w_en, ram_wea} !== {16'h1234, 8'hA5, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL mux_write: got %h/%h/%b/%b expected 1234/a5/1/1", ram_w_addr, ram_w_data, ram_w_en, ram_wea);
        end
        n_checks++;
        if (rom_addr !== 15'h0ABC || rom_en !== 1'b1) begin
            n_fail++; $display("FAIL mux_rom: got %h/%b expected 0abc/1", rom_addr, rom_en);
        end
        phase_done = 3'b010;
        tick();
        phase_done = '0;
        n_checks++;
        if (dbg_state !== ST_RUN || cur_phase !== 3'd1 || ram_w_addr !== 16'h1234) begin
            n_fail++; $display("FAIL foreign_done: got state %0d phase %0d addr %h expected 1/1/1234", dbg_state, cur_phase, ram_w_addr);
        end
        tick();
        n_checks++;
        if (phase_start !== '0 || dbg_state !== ST_RUN) begin
            n_fail++; $display("FAIL foreign_done_hold: got %b/%0d expected 000/1", phase_start, dbg_state);
        end
        phase_done = 3'b100;
        tick();
        phase_done = '0;
        repeat (3) tick();
        n_checks++;
        if (phase_start !== 3'b010 || cur_phase !== 3'd2) begin
            n_fail++; $display("FAIL phase2_start: got %b/%0d expected 010/2", phase_start, cur_phase);
        end
    endtask

    task automatic test_reset_mid_run();
        bit bad;
        cl_ram_r_addr[1*AW +: AW] = 16'h4444; cl_ram_r_en[1] = 1'b1;
        cl_ram_w_addr[1*AW +: AW] = 16'h5555; cl_ram_w_en[1] = 1'b1;
        tick();
        n_checks++;
        if (ram_r_en !== 1'b1 || ram_r_addr !== 16'h4444) begin
            n_fail++; $display("FAIL phase2_grant: got %b/%h expected 1/4444", ram_r_en, ram_r_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ram_w_addr, ram_w_data, ram_w_en, ram_wea, ram_r_addr, ram_r_en, rom_addr, rom_en} !== '0) begin
            n_fail++; $display("FAIL abort_ports: got %h expected 0",
                {ram_w_addr, ram_w_data, ram_w_en, ram_wea, ram_r_addr, ram_r_en, rom_addr, rom_en});
        end
        n_checks++;
        if ({phase_start, cur_phase, busy, all_done, dbg_state} !== '0) begin
            n_fail++; $display("FAIL abort_ctrl: got %h expected 0", {phase_start, cur_phase, busy, all_done, dbg_state});
        end
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (phase_start !== '0 || dbg_state !== ST_IDLE) bad = 1;
        end
        n_checks++;
        if (bad) begin
            n_fail++; $display("FAIL post_abort_idle: got phase_start %b state %0d expected 000/0", phase_start, dbg_state);
        end
    endtask

    initial begin
        test_reset();
        test_phase_order();
        test_tb_read();
        test_rerun_mux();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
